// File: rtl/seq_pkg.sv
// Shared definitions for the seq_tx bit-stuffing serial framer.
package seq_pkg;

    localparam int unsigned FLAG_LEN  = 7;
    localparam int unsigned STUFF_RUN = 4;
    localparam logic [FLAG_LEN-1:0] FLAG = 7'b0111110;

    localparam int unsigned FCNT_W = $clog2(FLAG_LEN);
    localparam int unsigned RUN_W  = $clog2(STUFF_RUN + 1);

    typedef enum logic [2:0] {
        IDLE,
        OPEN,
        DATA,
        STUFF,
        CLOSE,
        FIN
    } state_t;

endpackage

// File: rtl/seq_tx.sv
// Serial frame transmitter: opening flag, LSB-first payload with zero stuffing
// after every run of STUFF_RUN ones, closing flag, then a one-cycle done.
module seq_tx
    import seq_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] din,
    output logic              out,
    output logic              busy,
    output logic              done
);

    localparam int unsigned BIT_W = $clog2(DATA_W + 1);

    state_t              state;
    logic [FCNT_W-1:0]   flag_cnt;
    logic [BIT_W-1:0]    bit_cnt;
    logic [RUN_W-1:0]    run;
    logic [DATA_W-1:0]   shreg;

    logic                last_flag_c;
    logic                payload_done_c;
    logic                run_full_c;
    logic                emit_c;
    logic                to_close_c;
    logic                flag_nxt_c;

    // Transition decisions shared by several states; out is registered, so each
    // edge loads the bit belonging to the cycle being entered.
    always_comb begin
        last_flag_c    = (flag_cnt == FCNT_W'(FLAG_LEN - 1));
        payload_done_c = (bit_cnt == BIT_W'(DATA_W));
        run_full_c     = (run == RUN_W'(STUFF_RUN));
        emit_c         = 1'b0;
        to_close_c     = 1'b0;
        flag_nxt_c     = 1'b1;
        if (!last_flag_c) begin
            flag_nxt_c = FLAG[FCNT_W'(FLAG_LEN - 2) - flag_cnt];
        end
        case (state)
            OPEN:  emit_c = last_flag_c;
            DATA: begin
                emit_c     = !run_full_c && !payload_done_c;
                to_close_c = !run_full_c && payload_done_c;
            end
            STUFF: begin
                emit_c     = !payload_done_c;
                to_close_c = payload_done_c;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            flag_cnt <= '0;
            bit_cnt  <= '0;
            run      <= '0;
            shreg    <= '0;
            out      <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (emit_c) begin
                // Consume one payload bit; any transmitted 0 ends the ones-run.
                state   <= DATA;
                out     <= shreg[0];
                shreg   <= shreg >> 1;
                bit_cnt <= bit_cnt + BIT_W'(1);
                run     <= shreg[0] ? run + RUN_W'(1) : '0;
            end else if (to_close_c) begin
                state    <= CLOSE;
                flag_cnt <= '0;
                out      <= FLAG[FLAG_LEN-1];
            end else begin
                case (state)
                    IDLE: begin
                        out <= 1'b1;
                        if (start) begin
                            state    <= OPEN;
                            shreg    <= din;
                            flag_cnt <= '0;
                            bit_cnt  <= '0;
                            run      <= '0;
                            out      <= FLAG[FLAG_LEN-1];
                            busy     <= 1'b1;
                        end
                    end
                    OPEN: begin
                        flag_cnt <= flag_cnt + FCNT_W'(1);
                        out      <= flag_nxt_c;
                    end
                    DATA: begin
                        state <= STUFF;
                        out   <= 1'b0;
                        run   <= '0;
                    end
                    CLOSE: begin
                        if (last_flag_c) begin
                            state <= FIN;
                            out   <= 1'b1;
                            done  <= 1'b1;
                        end else begin
                            flag_cnt <= flag_cnt + FCNT_W'(1);
                            out      <= flag_nxt_c;
                        end
                    end
                    FIN: begin
                        state <= IDLE;
                        out   <= 1'b1;
                        busy  <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
